// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the scratch-RAM arbiter: FSM state codes and port indices.
// Optional feature macro used by this slice: RAM_ARB_RR_EN (round-robin tie-break).
package ram_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE   = 2'b00;
    localparam arb_state_t ACCESS = 2'b01;
    localparam arb_state_t RESP   = 2'b10;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner selection between the two requesters.
// RAM_ARB_RR_EN selects round-robin tie-break; otherwise port 0 has fixed priority.
module ram_arb_pick
    import ram_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
`ifdef RAM_ARB_RR_EN
    input  logic last,
`endif
    output logic winner,
    output logic any_req
);

    always_comb begin
        any_req = req0 | req1;
        winner  = PORT0;
        if (req0 && req1) begin
`ifdef RAM_ARB_RR_EN
            // On a tie the port that was not granted most recently wins.
            winner = ~last;
`else
            winner = PORT0;
`endif
        end else if (req1) begin
            winner = PORT1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for the single-port synchronous scratch RAM.
// Define RAM_ARB_RR_EN for round-robin tie-break; default build is fixed priority (port 0).
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  REQ0,
    input  logic                  WE0,
    input  logic [ADDR_WIDTH-1:0] ADDR0,
    input  logic [WIDTH-1:0]      DIN0,
    input  logic                  REQ1,
    input  logic                  WE1,
    input  logic [ADDR_WIDTH-1:0] ADDR1,
    input  logic [WIDTH-1:0]      DIN1,
    output logic                  ACK0,
    output logic                  ACK1,
    output logic [WIDTH-1:0]      RDATA,
    output logic                  RAM_CE,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic [WIDTH-1:0]      RAM_DIN,
    input  logic [WIDTH-1:0]      RAM_DOUT
);

    arb_state_t            state;
    logic                  win_q;
    logic                  ram_ce_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [WIDTH-1:0]      ram_din_q;
    logic                  ack0_q;
    logic                  ack1_q;
    logic                  winner;
    logic                  any_req;
`ifdef RAM_ARB_RR_EN
    logic                  last_q;
`endif

    ram_arb_pick u_pick (
        .req0    (REQ0),
        .req1    (REQ1),
`ifdef RAM_ARB_RR_EN
        .last    (last_q),
`endif
        .winner  (winner),
        .any_req (any_req)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            win_q      <= PORT0;
            ram_ce_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
`ifdef RAM_ARB_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= ACCESS;
                        win_q <= winner;
                        if (winner == PORT1) begin
                            ram_addr_q <= ADDR1;
                            ram_din_q  <= DIN1;
                            ram_ce_q   <= WE1;
                        end else begin
                            ram_addr_q <= ADDR0;
                            ram_din_q  <= DIN0;
                            ram_ce_q   <= WE0;
                        end
`ifdef RAM_ARB_RR_EN
                        last_q <= winner;
`endif
                    end
                end
                ACCESS: begin
                    // RAM samples on this edge; the grant completes regardless of REQ.
                    ram_ce_q <= 1'b0;
                    ack0_q   <= (win_q == PORT0);
                    ack1_q   <= (win_q == PORT1);
                    state    <= RESP;
                end
                RESP: begin
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    ram_ce_q <= 1'b0;
                    ack0_q   <= 1'b0;
                    ack1_q   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign ACK0     = ack0_q;
    assign ACK1     = ack1_q;
    assign RAM_CE   = ram_ce_q;
    assign RAM_ADDR = ram_addr_q;
    assign RAM_DIN  = ram_din_q;
    assign RDATA    = RAM_DOUT;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural RAM and a transaction-level reference model.
// Honours RAM_ARB_RR_EN the same way as the design.
module tb_ram_arbiter;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       REQ0 = 1'b0, WE0 = 1'b0, REQ1 = 1'b0, WE1 = 1'b0;
    logic [3:0] ADDR0 = '0, ADDR1 = '0;
    logic [7:0] DIN0 = '0, DIN1 = '0;
    logic       ACK0, ACK1, RAM_CE;
    logic [7:0] RDATA, RAM_DIN;
    logic [3:0] RAM_ADDR;
    logic [7:0] RAM_DOUT = '0;

    ram_arbiter #(.ADDR_WIDTH(4), .WIDTH(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .DIN0(DIN0),
        .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .DIN1(DIN1),
        .ACK0(ACK0), .ACK1(ACK1), .RDATA(RDATA),
        .RAM_CE(RAM_CE), .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN), .RAM_DOUT(RAM_DOUT)
    );

    always #5 CLK = ~CLK;

    // Behavioural single-port RAM: registered read returns the pre-write word.
    logic [7:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = '0;
    always @(posedge CLK) begin
        if (RAM_CE) mem[RAM_ADDR] <= RAM_DIN;
        RAM_DOUT <= mem[RAM_ADDR];
    end

    int cyc_cnt = 0;
    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        bit         port;
        bit         we;
        logic [3:0] addr;
        logic [7:0] data;   // read data expected, or old word for a write
        int         cyc;
    } exp_t;
    exp_t sbq[$];

    // Reference model state
    logic [7:0] ref_mem [16];
    bit         m_last;
    bit         p_valid [2];
    bit         p_we    [2];
    logic [3:0] p_addr  [2];
    logic [7:0] p_din   [2];

    // Monitor: every ACK pops one expectation.
    always @(negedge CLK) begin
        if (RST_N && (ACK0 || ACK1)) begin
            if (ACK0 && ACK1) begin
                chk("ack_both", {ACK1, ACK0}, 2'b01);
            end else if (sbq.size() == 0) begin
                chk("ack_unexpected", {ACK1, ACK0}, 2'b00);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("ack_port", ACK1, e.port);
                chk("ack_cycle", cyc_cnt, e.cyc);
                if (!e.we) chk("rdata", RDATA, e.data);
            end
        end
    end

    task automatic apply_reqs();
        REQ0 = p_valid[0]; WE0 = p_we[0]; ADDR0 = p_addr[0]; DIN0 = p_din[0];
        REQ1 = p_valid[1]; WE1 = p_we[1]; ADDR1 = p_addr[1]; DIN1 = p_din[1];
    endtask

    task automatic set_req(input int p, input bit we, input logic [3:0] a, input logic [7:0] d);
        p_valid[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_din[p] = d;
    endtask

    // One arbitration round starting at a negedge with the DUT idle.
    task automatic do_round(input bit abandon);
        bit   w;
        exp_t e;
        if (!(p_valid[0] || p_valid[1])) begin
            apply_reqs();
            @(negedge CLK);
            return;
        end
        if (p_valid[0] && p_valid[1]) begin
`ifdef RAM_ARB_RR_EN
            w = !m_last;
`else
            w = 1'b0;
`endif
        end else begin
            w = p_valid[1];
        end
        m_last = w;
        e.port = w; e.we = p_we[w]; e.addr = p_addr[w];
        e.data = ref_mem[p_addr[w]];
        e.cyc  = cyc_cnt + 2;
        if (p_we[w]) ref_mem[p_addr[w]] = p_din[w];
        sbq.push_back(e);
        chk("idle_ce", RAM_CE, 1'b0);
        apply_reqs();
        @(negedge CLK);
        chk("access_ce", RAM_CE, e.we);
        chk("access_addr", RAM_ADDR, e.addr);
        if (e.we) chk("access_din", RAM_DIN, p_din[w]);
        if (abandon) begin
            if (w) REQ1 = 1'b0; else REQ0 = 1'b0;
        end
        @(negedge CLK);
        chk("resp_ce", RAM_CE, 1'b0);
        if (e.we) chk("resp_old_word", RAM_DOUT, e.data);
        p_valid[w] = 1'b0;
        @(negedge CLK);
        chk("post_ce", RAM_CE, 1'b0);
        chk("post_ack", {ACK1, ACK0}, 2'b00);
        apply_reqs();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        m_last = 1'b1;
        for (int p = 0; p < 2; p++) begin
            p_valid[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_din[p] = '0;
        end

        #12;
        chk("rst_ce", RAM_CE, 1'b0);
        chk("rst_addr", RAM_ADDR, 4'h0);
        chk("rst_din", RAM_DIN, 8'h00);
        chk("rst_acks", {ACK1, ACK0}, 2'b00);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        // Tie straight after reset, winner re-raised each time
        for (int r = 0; r < 4; r++) begin
            if (!p_valid[0]) set_req(0, 1'b0, 4'(r), 8'h00);
            if (!p_valid[1]) set_req(1, 1'b0, 4'(r + 8), 8'h00);
            do_round(1'b0);
        end
        p_valid[0] = 1'b0; p_valid[1] = 1'b0;
        apply_reqs();
        @(negedge CLK);

        // Single write then read on port 0
        set_req(0, 1'b1, 4'd3, 8'hA5); do_round(1'b0);
        set_req(0, 1'b0, 4'd3, 8'h00); do_round(1'b0);

        // Cross-port coherency at the top address
        set_req(1, 1'b1, 4'd15, 8'h3C); do_round(1'b0);
        set_req(0, 1'b0, 4'd15, 8'h00); do_round(1'b0);

        // Abandoned request on port 1, then port 0 is served
        set_req(1, 1'b0, 4'd3, 8'h00); do_round(1'b1);
        set_req(0, 1'b0, 4'd15, 8'h00); do_round(1'b0);

        // Write over old data: RESP shows the old word
        set_req(0, 1'b1, 4'd7, 8'h22); do_round(1'b0);
        set_req(0, 1'b1, 4'd7, 8'h11); do_round(1'b0);
        set_req(0, 1'b0, 4'd7, 8'h00); do_round(1'b0);

        // Reset during ACCESS of a write: the write is lost
        set_req(0, 1'b1, 4'd5, 8'h40); do_round(1'b0);
        set_req(0, 1'b1, 4'd5, 8'h77);
        apply_reqs();
        @(negedge CLK);
        chk("mid_access_ce", RAM_CE, 1'b1);
        RST_N = 1'b0;
        #1;
        chk("mid_rst_ce", RAM_CE, 1'b0);
        chk("mid_rst_acks", {ACK1, ACK0}, 2'b00);
        chk("mid_rst_addr", RAM_ADDR, 4'h0);
        p_valid[0] = 1'b0;
        apply_reqs();
        m_last = 1'b1;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        set_req(0, 1'b0, 4'd5, 8'h00); do_round(1'b0);

        // Randomised traffic
        for (int r = 0; r < 120; r++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_valid[p] && $urandom_range(0, 9) < 6)
                    set_req(p, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                            8'($urandom_range(0, 255)));
            end
            do_round($urandom_range(0, 9) < 2);
        end
        p_valid[0] = 1'b0; p_valid[1] = 1'b0;
        apply_reqs();
        repeat (4) @(negedge CLK);

        chk("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter and sequencer for the single-port synchronous scratch RAM (registered read, one access per clock, write-enable input `CE`). It accepts read/write requests from two masters, such as the CPU core (port 0) and the I/O loader (port 1), and grants them one at a time. It drives the RAM address, write data and write enable, and returns read data with a one-cycle acknowledge. It sits between the masters and the RAM, and it is the only block that drives the RAM ports.

## Interface
Parameters:
- `ADDR_WIDTH`, default 4: RAM address width; must match the RAM instance.
- `WIDTH`, default 8: data word width; must match the RAM instance.

Ports:
- `CLK`  input  1  clock; everything samples on the rising edge.
- `RST_N`  input  1  reset, asynchronous assert, active-low.
- `REQ0` / `REQ1`  input  1  access request; held until the matching ACK is sampled.
- `WE0` / `WE1`  input  1  1 = write, 0 = read; stable while REQ is high.
- `ADDR0` / `ADDR1`  input  ADDR_WIDTH  word address; stable while REQ is high.
- `DIN0` / `DIN1`  input  WIDTH  write data; stable while REQ is high.
- `ACK0` / `ACK1`  output  1  one-cycle completion pulse for the granted port.
- `RDATA`  output  WIDTH  read data; valid only while ACK0 or ACK1 is high for a read.
- `RAM_CE`  output  1  to RAM `CE` (write enable).
- `RAM_ADDR`  output  ADDR_WIDTH  to RAM `ADDR`.
- `RAM_DIN`  output  WIDTH  to RAM `DATA_IN`.
- `RAM_DOUT`  input  WIDTH  from RAM `DATA_OUT`.

## Operation
- State machine with three states:
  - IDLE: if REQ0 or REQ1 is high, pick a winner and load the winner's ADDR/DIN into RAM_ADDR/RAM_DIN. Set RAM_CE = winner's WE. Go to ACCESS.
  - ACCESS: the RAM samples on the closing edge. On that edge clear RAM_CE, set the winner's ACK, and go to RESP.
  - RESP: the winner's ACK is high for this cycle only. RDATA = RAM_DOUT (pass-through). On the closing edge clear ACK and go to IDLE unconditionally.
- Selection with one request pending: that port wins.
- Selection with both pending: round-robin. The port not granted last wins. A 1-bit `last` register resets to 1, so port 0 wins the first tie.
- Worst-case wait with both ports busy: one foreign access (3 cycles).
- A granted access always completes. If REQ drops during ACCESS or RESP, the ACK is still pulsed and is ignored by the master.
- Request inputs are ignored outside IDLE.
- For a write, RAM_DOUT during RESP holds the old word; RDATA is don't-care.
- RAM_CE is high in ACCESS only, and only for writes. It is never high in IDLE or RESP, so no spurious writes occur.
- Reset values:
  - State IDLE, `last` = 1.
  - RAM_CE = 0, RAM_ADDR = 0, RAM_DIN = 0.
  - ACK0 = ACK1 = 0.

## Timing
- REQ is sampled high at edge k while the block is in IDLE.
- Edge k to k+1: ACCESS, with RAM signals driven from registers.
- Edge k+1: the RAM writes or loads DATA_OUT.
- Edge k+1 to k+2: RESP. ACK is high and RDATA is valid.
- The master samples ACK at edge k+2 and drops or changes REQ after it.
- Edge k+2 to k+3: mandatory IDLE. The next grant is sampled at k+3.
- Latency is 2 cycles from the request sample to the ACK cycle. Throughput is one access per 3 cycles.
- Reset asserted mid-operation:
  - All outputs are cleared immediately and asynchronously, and no ACK is issued.
  - A write in ACCESS is lost if reset arrives before edge k+1.
  - Masters must reissue the request.

## Configuration
- `RAM_ARB_RR_EN` defined: round-robin tie-break as described above.
- `RAM_ARB_RR_EN` undefined:
  - Fixed priority, port 0 always wins a tie.
  - `last` is removed.
  - Port 1 can starve while REQ0 is re-raised every IDLE.

## Structure
- Shared package holds:
  - state encodings: IDLE = 2'b00, ACCESS = 2'b01, RESP = 2'b10;
  - port index constants: PORT0 = 0, PORT1 = 1.
- One sub-module, `ram_arb_pick`. It is combinational: it takes REQ0, REQ1 and `last`, and returns a 1-bit winner and `any_req`. Round-robin versus fixed priority is selected inside it under `RAM_ARB_RR_EN`.
- FSM, registers and muxes live in `ram_arbiter`.

## Test plan
- Single write, then read:
  - Port 0 writes ADDR=3, DIN=0xA5: RAM_CE is high for exactly one cycle (ACCESS), and ACK0 pulses 2 cycles after the REQ sample.
  - Port 0 then reads ADDR=3: RDATA=0xA5 with ACK0, and ACK1 stays 0 throughout.
- Tie after reset:
  - REQ0 and REQ1 are held high together and re-raised after each ACK.
  - With RR_EN: grants go 0,1,0,1, with each ACK 3 cycles apart.
  - Without RR_EN: grants go 0,0,0 while REQ0 is re-raised.
- Cross-port coherency with max address: port 1 writes ADDR=15, DIN=0x3C, then port 0 reads ADDR=15 and gets RDATA=0x3C.
- Abandoned request: REQ1 drops during ACCESS. ACK1 still pulses once, the state returns to IDLE, and port 0 is granted on its next request.
- Reset mid-access: RST_N goes low during ACCESS of a write to ADDR=5. RAM_CE and all ACKs go to 0 immediately, and the state is IDLE after release.
- Write-cycle RDATA is ignored: a port 0 write to ADDR=7 with DIN=0x11 over old data 0x22 shows RAM_DOUT=0x22 in RESP. The next read of ADDR=7 returns 0x11.
